multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-32 datapath.
- Consumes `opcode` from the instruction field decoder. Sequences fetch, decode, execute, memory and writeback phases, and drives every datapath mux and enable.
- Stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.
- Sits beside the datapath; the IR feeds the field decoder, which feeds this block.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- opcode  in  6  instruction[31:26] from the field decoder; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if branch condition met.
- branch_ne  out  1  0 = beq (take on zero), 1 = bne (take on not-zero).
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct, 11 = use opcode (I-type).
- reg_write  out  1  register file write enable.
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31.
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
- illegal_op  out  1  sticky flag: unsupported opcode seen.
- instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Control outputs are Moore decodes of state. The only input dependency is `mem_ready`, which gates the FETCH commit signals.
- Any output not listed for a state is 0.
- Reset (`rst_n` = 0, asynchronous):
  - state = FETCH; `illegal_op` = 0; `instr_retired` = 0.
  - Outputs take FETCH values with `mem_ready` treated as 0.
  - Reset mid-instruction abandons the instruction; no count.
- FETCH:
  - Always: `mem_req` = `mem_read` = 1, `i_or_d` = 0, `alu_src_a` = 0, `alu_src_b` = 01, `alu_op` = 00, `pc_source` = 00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Hold in FETCH until `mem_ready`, then go to DECODE.
- DECODE:
  - `alu_src_a` = 0, `alu_src_b` = 11, `alu_op` = 00 (branch target into ALUOut).
  - Next state by opcode:
    - 100011 / 101011 → MEM_ADDR
    - 000000 → R_EXEC
    - 001000 / 001100 / 001101 / 001010 → I_EXEC
    - 000100 / 000101 → BRANCH
    - 000010 / 000011 → JUMP
    - anything else: set `illegal_op`, go to FETCH, no count.
- MEM_ADDR:
  - `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 00.
  - lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ:
  - `mem_req` = `mem_read` = 1, `i_or_d` = 1.
  - Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write` = 1, `reg_dst` = 00, `mem_to_reg` = 01; go to FETCH, count.
- MEM_WRITE:
  - `mem_req` = `mem_write` = 1, `i_or_d` = 1.
  - Hold until `mem_ready`, then go to FETCH, count.
- R_EXEC: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 10; go to R_WB.
- R_WB: `reg_write` = 1, `reg_dst` = 01, `mem_to_reg` = 00; go to FETCH, count.
- I_EXEC: `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 11; go to I_WB.
- I_WB: `reg_write` = 1, `reg_dst` = 00, `mem_to_reg` = 00; go to FETCH, count.
- BRANCH:
  - `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 01, `pc_write_cond` = 1, `pc_source` = 01.
  - `branch_ne` = 1 iff opcode is 000101.
  - Go to FETCH, count.
- JUMP:
  - `pc_write` = 1, `pc_source` = 10.
  - If opcode is 000011 (jal): also `reg_write` = 1, `reg_dst` = 10, `mem_to_reg` = 10. The PC value written is the already-incremented PC+4.
  - Go to FETCH, count.
- Latency with zero-wait memory: lw 5, sw/R/I 4, branch/jump 3 cycles. Each cycle that `mem_ready` is low adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- `mem_ready` asserted outside a requesting state is ignored.
- Counter: increments by 1 in the final state of each instruction and wraps from all-ones to 0.
- `illegal_op` clears only on reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI);
  - state encoding;
  - alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg encodings.
- ALU function decode (`alu_op` + funct/opcode → ALU operation) is a separate sub-module, alu_control, shared with the datapath. It is not part of this block.

Test Plan:
- Reset → first instruction: release `rst_n` with `mem_ready` = 1, opcode 100011 (lw) → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. `reg_write` = 1 with `mem_to_reg` = 01 in cycle 5; `instr_retired` = 1.
- R-type then beq: opcode 000000 → `alu_op` = 10 in R_EXEC; `reg_write` with `reg_dst` = 01 in cycle 4. Then opcode 000100 → `pc_write_cond` = 1, `branch_ne` = 0, `pc_source` = 01 in cycle 3; `instr_retired` = 2.
- Memory stall: sw with `mem_ready` low for 3 cycles in FETCH and 2 in MEM_WRITE → total 9 cycles. `ir_write` asserts only on the ready cycle; `mem_write` is held for 3 cycles.
- jal: opcode 000011 → cycle 3 shows `pc_write` = 1, `pc_source` = 10, `reg_write` = 1, `reg_dst` = 10, `mem_to_reg` = 10.
- Illegal opcode: opcode 111111 → `illegal_op` rises after DECODE and returns to FETCH; `instr_retired` is unchanged. The flag stays set across a following legal addi (opcode 001000).
- Reset mid-op: assert `rst_n` = 0 during MEM_READ → outputs immediately take FETCH values; `instr_retired` = 0 and `illegal_op` = 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-32 control path: opcodes, FSM
// states, datapath mux encodings and the per-state control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_OPC} alu_op_e;
  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_e;
  typedef enum logic [1:0] {PCS_ALU, PCS_ALUOUT, PCS_JUMP, PCS_RSVD} pc_source_e;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA, DST_RSVD} reg_dst_e;
  typedef enum logic [1:0] {M2R_ALUOUT, M2R_MDR, M2R_PC, M2R_RSVD} mem_to_reg_e;

  typedef struct packed {
    logic        fetch;
    logic        mem_req;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    pc_source_e  pc_source;
    logic        alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
    logic        reg_write;
    reg_dst_e    reg_dst;
    mem_to_reg_e mem_to_reg;
  } ctrl_t;

  // FETCH word; its ir_write/pc_write commits are added later, gated by mem_ready.
  localparam ctrl_t CTRL_FETCH = '{fetch: 1'b1, mem_req: 1'b1, mem_read: 1'b1,
    mem_write: 1'b0, i_or_d: 1'b0, pc_write: 1'b0, pc_write_cond: 1'b0,
    branch_ne: 1'b0, pc_source: PCS_ALU, alu_src_a: 1'b0, alu_src_b: SRCB_FOUR,
    alu_op: ALU_ADD, reg_write: 1'b0, reg_dst: DST_RT, mem_to_reg: M2R_ALUOUT};

  // Opcode dispatch out of DECODE; S_FETCH marks an unsupported opcode.
  function automatic state_e dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                      return S_MEM_ADDR;
      OP_RTYPE:                          return S_R_EXEC;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_I_EXEC;
      OP_BEQ, OP_BNE:                    return S_BRANCH;
      OP_J, OP_JAL:                      return S_JUMP;
      default:                           return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: opcode/memory handshake in, mux selects and enables out.
interface multicycle_control_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             mem_req, mem_read, mem_write, i_or_d, ir_write;
  logic             pc_write, pc_write_cond, branch_ne;
  logic [1:0]       pc_source;
  logic             alu_src_a;
  logic [1:0]       alu_src_b, alu_op;
  logic             reg_write;
  logic [1:0]       reg_dst, mem_to_reg;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
           pc_write_cond, branch_ne, pc_source, alu_src_a, alu_src_b, alu_op,
           reg_write, reg_dst, mem_to_reg, illegal_op, instr_retired
  );
  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
           pc_write_cond, branch_ne, pc_source, alu_src_a, alu_src_b, alu_op,
           reg_write, reg_dst, mem_to_reg, illegal_op, instr_retired
  );
endinterface

// File: rtl/multicycle_control_outdec.sv
// Moore control word for a state; the top feeds it the next state so outputs are registered.
module multicycle_control_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH:     ctrl = CTRL_FETCH;
      S_DECODE:    ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RD;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OPC;
      end
      S_I_WB:      ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
        // jal links the PC register, which already holds PC+4 from FETCH
        if (opcode == OP_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = DST_RA;
          ctrl.mem_to_reg = M2R_PC;
        end
      end
      default:     ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-32 main control FSM: sequences instruction phases, stalls on
// mem_ready, flags illegal opcodes and counts retired instructions.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_control_if.master bus
);
  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = dispatch(bus.opcode);
        if (state_d == S_FETCH) illegal_d = 1'b1;
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (bus.mem_ready) begin
        state_d = S_FETCH;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default:     state_d = S_FETCH;
    endcase
  end

  multicycle_control_outdec u_outdec (
    .state  (state_d),
    .opcode (bus.opcode),
    .ctrl   (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= CTRL_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // FETCH commits only on the ready cycle; held in reset, mem_ready is ignored.
  logic fetch_commit;
  assign fetch_commit = ctrl_q.fetch & bus.mem_ready & rst_n;

  assign bus.mem_req       = ctrl_q.mem_req;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.ir_write      = fetch_commit;
  assign bus.pc_write      = ctrl_q.pc_write | fetch_commit;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.branch_ne     = ctrl_q.branch_ne;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.illegal_op    = illegal_q;
  assign bus.instr_retired = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-plan model checked every
// cycle, plus literal checks from hand-worked cycle timelines.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- model: each instruction is a list of phases after DECODE ----
  localparam int PH_F = 0, PH_D = 1, PH_ADDR = 2, PH_RD = 3, PH_LDWB = 4,
                 PH_WR = 5, PH_REX = 6, PH_RWB = 7, PH_IEX = 8, PH_IWB = 9,
                 PH_BR = 10, PH_J = 11;
  int          m_ph;
  int          plan[$];
  logic [31:0] m_cnt;
  logic        m_ill;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = PH_F; plan.delete(); m_cnt = 0; m_ill = 1'b0;
    end else if ((m_ph == PH_F || m_ph == PH_RD || m_ph == PH_WR) && !bus.mem_ready) begin
      m_ph = m_ph;
    end else if (m_ph == PH_F) begin
      m_ph = PH_D;
    end else if (m_ph == PH_D) begin
      case (bus.opcode)
        OP_LW:                             plan = '{PH_ADDR, PH_RD, PH_LDWB};
        OP_SW:                             plan = '{PH_ADDR, PH_WR};
        OP_RTYPE:                          plan = '{PH_REX, PH_RWB};
        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: plan = '{PH_IEX, PH_IWB};
        OP_BEQ, OP_BNE:                    plan = '{PH_BR};
        OP_J, OP_JAL:                      plan = '{PH_J};
        default:                           plan.delete();
      endcase
      if (plan.size() == 0) begin m_ill = 1'b1; m_ph = PH_F; end
      else m_ph = plan.pop_front();
    end else if (plan.size() == 0) begin
      m_cnt = m_cnt + 1; m_ph = PH_F;
    end else begin
      m_ph = plan.pop_front();
    end
  end

  // {mem_req,mem_read,mem_write,i_or_d,ir_write,pc_write,pc_write_cond,branch_ne,
  //  pc_source,alu_src_a,alu_src_b,alu_op,reg_write,reg_dst,mem_to_reg}
  function automatic logic [19:0] exp_out(input int ph, input logic [5:0] op, input logic rdy);
    logic mreq = 0, mrd = 0, mwr = 0, iod = 0, irw = 0, pcw = 0, pcwc = 0, bne = 0;
    logic srca = 0, rw = 0;
    logic [1:0] pcs = 0, srcb = 0, aop = 0, dst = 0, m2r = 0;
    case (ph)
      PH_F:    begin mreq = 1; mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      PH_D:    srcb = 2'b11;
      PH_ADDR: begin srca = 1; srcb = 2'b10; end
      PH_RD:   begin mreq = 1; mrd = 1; iod = 1; end
      PH_LDWB: begin rw = 1; m2r = 2'b01; end
      PH_WR:   begin mreq = 1; mwr = 1; iod = 1; end
      PH_REX:  begin srca = 1; aop = 2'b10; end
      PH_RWB:  begin rw = 1; dst = 2'b01; end
      PH_IEX:  begin srca = 1; srcb = 2'b10; aop = 2'b11; end
      PH_IWB:  rw = 1;
      PH_BR:   begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = (op == 6'b000101); end
      PH_J: begin
        pcw = 1; pcs = 2'b10;
        if (op == 6'b000011) begin rw = 1; dst = 2'b10; m2r = 2'b10; end
      end
      default: ;
    endcase
    return {mreq, mrd, mwr, iod, irw, pcw, pcwc, bne, pcs, srca, srcb, aop, rw, dst, m2r};
  endfunction

  logic [19:0] act_vec;
  assign act_vec = {bus.mem_req, bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                    bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_source,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
                    bus.reg_dst, bus.mem_to_reg};

  logic run_en = 1'b0;
  always @(negedge clk) begin
    if (run_en && rst_n) begin
      chk("ctrl_word", {12'd0, act_vec}, {12'd0, exp_out(m_ph, bus.opcode, bus.mem_ready)});
      chk("illegal_op", {31'd0, bus.illegal_op}, {31'd0, m_ill});
      chk("instr_retired", bus.instr_retired, m_cnt);
    end
  end

  // ---- stimulus: inputs change 1 time unit after the rising edge ----
  task automatic setin(input logic [5:0] op, input logic rdy);
    bus.opcode = op; bus.mem_ready = rdy; #2;
  endtask
  task automatic nxt();
    @(posedge clk); #1;
  endtask
  task automatic tick(input logic [5:0] op, input logic rdy);
    setin(op, rdy); nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] base;
  logic        sw_pat [0:8] = '{0, 0, 0, 1, 1, 1, 0, 0, 1};
  int          ncyc, nwr, nir;

  initial begin
    bus.opcode = '0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    // Held in reset with mem_ready high: FETCH word but no commits.
    setin(OP_LW, 1'b1);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 1);
    chk("rst_ir_write", {31'd0, bus.ir_write}, 0);
    chk("rst_alu_src_b", {30'd0, bus.alu_src_b}, 2'b01);
    chk("rst_retired", bus.instr_retired, 0);
    rst_n = 1'b1; run_en = 1'b1;
    nxt();                                   // cycle 1 FETCH
    tick(OP_LW, 1'b1); tick(OP_LW, 1'b1); tick(OP_LW, 1'b1);
    setin(OP_LW, 1'b1);                      // cycle 5 MEM_WB
    chk("lw_wb", {28'd0, bus.reg_write, bus.reg_dst, bus.mem_to_reg[0]}, {28'd0, 4'b1001});
    nxt();
    chk("lw_retired", bus.instr_retired, 1);

    // R-type; mem_ready low in DECODE must be ignored
    base = bus.instr_retired;
    tick(OP_RTYPE, 1'b1); tick(OP_RTYPE, 1'b0);
    setin(OP_RTYPE, 1'b1); chk("r_alu_op", {30'd0, bus.alu_op}, 2'b10); nxt();
    setin(OP_RTYPE, 1'b1); chk("r_wb", {29'd0, bus.reg_write, bus.reg_dst}, 3'b101); nxt();
    tick(OP_BEQ, 1'b1); tick(OP_BEQ, 1'b1);
    setin(OP_BEQ, 1'b1);
    chk("beq", {28'd0, bus.pc_write_cond, bus.branch_ne, bus.pc_source}, {28'd0, 4'b1001});
    nxt();
    chk("r_beq_retired", bus.instr_retired - base, 2);

    // bne
    tick(OP_BNE, 1'b1); tick(OP_BNE, 1'b1);
    setin(OP_BNE, 1'b1); chk("bne_flag", {31'd0, bus.branch_ne}, 1); nxt();

    // sw with 3 FETCH and 2 MEM_WRITE wait cycles
    base = bus.instr_retired; ncyc = 0; nwr = 0; nir = 0;
    for (int i = 0; i < 9; i++) begin
      setin(OP_SW, sw_pat[i]);
      nwr += int'(bus.mem_write); nir += int'(bus.ir_write);
      if (i == 0) chk("sw_stall_ir", {31'd0, bus.ir_write}, 0);
      nxt(); ncyc++;
      if (bus.instr_retired != base) break;
    end
    chk("sw_cycles", ncyc, 9);
    chk("sw_mem_write_cycles", nwr, 3);
    chk("sw_ir_write_cycles", nir, 1);

    // jal
    tick(OP_JAL, 1'b1); tick(OP_JAL, 1'b1);
    setin(OP_JAL, 1'b1);
    chk("jal", {24'd0, bus.pc_write, bus.pc_source, bus.reg_write, bus.reg_dst, bus.mem_to_reg},
        {24'd0, 8'b1_10_1_10_10});
    nxt();

    // illegal opcode, then a legal addi
    base = bus.instr_retired;
    tick(6'b111111, 1'b1);
    setin(6'b111111, 1'b1); chk("ill_in_decode", {31'd0, bus.illegal_op}, 0); nxt();
    chk("ill_set", {31'd0, bus.illegal_op}, 1);
    chk("ill_no_count", bus.instr_retired, base);
    for (int i = 0; i < 4; i++) tick(OP_ADDI, 1'b1);
    chk("ill_sticky", {31'd0, bus.illegal_op}, 1);
    chk("addi_count", bus.instr_retired - base, 1);

    // ori with a late FETCH, j
    tick(OP_ORI, 1'b0); for (int i = 0; i < 4; i++) tick(OP_ORI, 1'b1);
    for (int i = 0; i < 3; i++) tick(OP_J, 1'b1);

    // reset during MEM_READ
    tick(OP_LW, 1'b1); tick(OP_LW, 1'b1); tick(OP_LW, 1'b1);
    setin(OP_LW, 1'b1);
    chk("pre_rst_i_or_d", {31'd0, bus.i_or_d}, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_word", {12'd0, act_vec}, {12'd0, 20'b1100_0000_00_0_01_00_0_00_00});
    chk("mid_rst_retired", bus.instr_retired, 0);
    chk("mid_rst_illegal", {31'd0, bus.illegal_op}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    nxt();
    for (int i = 0; i < 4; i++) tick(OP_ADDI, 1'b1);
    chk("post_rst_retired", bus.instr_retired, 1);

    run_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
